// File: rtl/hex_digits_pkg.sv
// hex_digits_pkg: shared definitions for the four-digit seven-segment scanner.
//   - state_e   : scanner FSM states (BLANK between digits, SHOW while lit)
//   - AN_OFF    : all digit enables released (active-low)
//   - SEG_OFF   : all segments off (active-low)
//   - SEG_TABLE : nibble -> seg_n[6:0] pattern, bit order {g,f,e,d,c,b,a}, active-low
package hex_digits_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble_i [3:0] : hex digit to display
//   seg_n_o  [6:0] : segments {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
    import hex_digits_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/hex_digits_scanner.sv
// hex_digits_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Each digit slot is CLK_DIV lit cycles followed by
// BLANK_CYCLES all-off cycles (ghost suppression); a full scan is 4 slots.
// The input value is captured into shadow registers when digit 0 is entered,
// so each scan shows one coherent value.
//
// Optional feature: define HEX_DIGITS_LZ_BLANK_EN to suppress leading zeros
// (digit i>=1 stays dark when nibbles i..3 are all zero; digit 0 always lit).
//
// Ports:
//   clk            : single clock
//   reset          : synchronous, active-high
//   hex_value[15:0]: nibble i drives digit i
//   dp[3:0]        : decimal point request per digit, 1 = lit
//   an_n[3:0]      : digit enables, active-low (one-hot-low or all-high)
//   seg_n[6:0]     : segments {g,f,e,d,c,b,a}, active-low
//   dp_n           : decimal point, active-low
module hex_digits_scanner
    import hex_digits_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hex_value,
    input  logic [3:0]  dp,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [CW-1:0] cnt_q;
    logic [15:0] shadow_val_q;
    logic [3:0]  shadow_dp_q;

    logic [1:0]  idx_d;
    logic [15:0] shadow_val_d;
    logic [3:0]  shadow_dp_d;
    logic [3:0]  nib_d;
    logic        lit_d;
    logic [6:0]  seg_dec;

    // Everything below describes the digit about to be entered, so the
    // outputs can be loaded on the same edge as the BLANK->SHOW transition.
    // Entering digit 0 uses the live inputs, which are captured that edge.
    always_comb begin
        idx_d        = idx_q + 2'd1;
        shadow_val_d = (idx_d == 2'd0) ? hex_value : shadow_val_q;
        shadow_dp_d  = (idx_d == 2'd0) ? dp        : shadow_dp_q;
        nib_d        = shadow_val_d[{idx_d, 2'b00} +: 4];
`ifdef HEX_DIGITS_LZ_BLANK_EN
        // Dark when this and every more significant nibble are zero.
        lit_d        = (idx_d == 2'd0) || ((shadow_val_d >> {idx_d, 2'b00}) != 16'h0);
`else
        lit_d        = 1'b1;
`endif
    end

    hex_to_7seg u_dec (
        .nibble_i (nib_d),
        .seg_n_o  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd3;
            cnt_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_n         <= AN_OFF;
            seg_n        <= SEG_OFF;
            dp_n         <= 1'b1;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q      <= ST_SHOW;
                        idx_q        <= idx_d;
                        cnt_q        <= '0;
                        shadow_val_q <= shadow_val_d;
                        shadow_dp_q  <= shadow_dp_d;
                        an_n         <= lit_d ? ~(4'b0001 << idx_d) : AN_OFF;
                        seg_n        <= lit_d ? seg_dec : SEG_OFF;
                        dp_n         <= lit_d ? ~shadow_dp_d[idx_d] : 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        an_n    <= AN_OFF;
                        seg_n   <= SEG_OFF;
                        dp_n    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                    cnt_q   <= '0;
                    an_n    <= AN_OFF;
                    seg_n   <= SEG_OFF;
                    dp_n    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_digits_scanner.sv
// Bench for hex_digits_scanner with CLK_DIV=4, BLANK_CYCLES=2.
// The reference model derives expected outputs from the number of clock
// edges since reset release: slot = ((n-2)/6)%4, lit for phases 0..3.
module tb_hex_digits_scanner;

    localparam int CD  = 4;
    localparam int BC  = 2;
    localparam int SLOT = CD + BC;
    localparam int SCAN = 4 * SLOT;

    localparam logic [6:0] TBL [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hv;
    logic [3:0]  dpv;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;

    int total = 0;
    int bad   = 0;

    // model state
    int          n = 0;
    logic        in_rst = 1'b1;
    logic [15:0] sh_v = '0;
    logic [3:0]  sh_d = '0;
    logic [11:0] got, exp;

    hex_digits_scanner #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .clk       (clk),
        .reset     (rst),
        .hex_value (hv),
        .dp        (dpv),
        .an_n      (an_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(int nn, logic r, logic [15:0] v, logic [3:0] d);
        int m, slot;
        logic lit;
        if (r || nn < BC) return OFF;
        m    = nn - BC;
        slot = (m / SLOT) % 4;
        if ((m % SLOT) >= CD) return OFF;
        lit = 1'b1;
`ifdef HEX_DIGITS_LZ_BLANK_EN
        if (slot != 0 && (v >> (slot * 4)) == 16'h0) lit = 1'b0;
`endif
        if (!lit) return OFF;
        return {~(4'b0001 << slot), TBL[v[slot*4 +: 4]], ~d[slot]};
    endfunction

    // Advance one clock, update the model from the inputs seen at that edge,
    // then sample the DUT 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            n = 0; in_rst = 1'b1; sh_v = '0; sh_d = '0;
        end else begin
            in_rst = 1'b0;
            n++;
            if (n >= BC && (n - BC) % SCAN == 0) begin
                sh_v = hv; sh_d = dpv;
            end
        end
        #1;
        exp = model(n, in_rst, sh_v, sh_d);
        got = {an_n, seg_n, dp_n};
    endtask

    function automatic int mpos();
        return (n >= BC) ? (n - BC) % SCAN : -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; hv = 16'h1234; dpv = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (got !== OFF) begin
                bad++; $display("FAIL reset got=%h exp=%h", got, OFF);
            end
        end
    endtask

    task automatic test_scan_1234();
        logic [11:0] k;
        rst = 1'b0;
        for (int i = 0; i < 2 * SCAN + 2; i++) begin
            tick();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL scan1234 n=%0d got=%h exp=%h", n, got, exp);
            end
            k = 12'h0;
            case (n)
                2, 26:   k = {4'hE, 7'h19, 1'b1};
                8:       k = {4'hD, 7'h30, 1'b1};
                14:      k = {4'hB, 7'h24, 1'b1};
                20:      k = {4'h7, 7'h79, 1'b1};
                0, 1, 6, 7, 25: k = OFF;
                default: k = 12'h0;
            endcase
            if (k != 12'h0) begin
                total++;
                if (got !== k) begin
                    bad++; $display("FAIL scan1234_fixed n=%0d got=%h exp=%h", n, got, k);
                end
            end
        end
    endtask

    task automatic test_decode();
        for (int k = 0; k < 16; k++) begin
            hv = 16'(k);
            for (int i = 0; i < SCAN; i++) begin
                tick();
                total++;
                if (got !== exp) begin
                    bad++; $display("FAIL decode n=%0d got=%h exp=%h", n, got, exp);
                end
                if (mpos() == 0) begin
                    total++;
                    if (seg_n !== TBL[k] || an_n !== 4'hE) begin
                        bad++; $display("FAIL decode_digit0 k=%0d got=%h/%h exp=%h/e", k, seg_n, an_n, TBL[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_midscan_change();
        int guard;
        hv = 16'hAAAA; dpv = 4'h0;
        guard = 0;
        do begin tick(); guard++; end while (mpos() != 0 && guard < 2 * SCAN);
        if (guard >= 2 * SCAN) begin total++; bad++; $display("FAIL midscan_align got=timeout exp=scan start"); end
        guard = 0;
        do begin tick(); guard++; end while (mpos() != 2 * SLOT + 1 && guard < 2 * SCAN);
        hv = 16'h5555;
        for (int i = 0; i < SCAN + 4; i++) begin
            tick();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL midscan n=%0d got=%h exp=%h", n, got, exp);
            end
            if (mpos() == 3 * SLOT || mpos() == 2 * SLOT + 3) begin
                total++;
                if (seg_n !== 7'h08) begin
                    bad++; $display("FAIL midscan_old got=%h exp=08", seg_n);
                end
            end
            if (mpos() == 0 || mpos() == 2 * SLOT) begin
                total++;
                if (seg_n !== 7'h12) begin
                    bad++; $display("FAIL midscan_new got=%h exp=12", seg_n);
                end
            end
            if (mpos() == 2 * SLOT) break;
        end
    endtask

    task automatic test_dp();
        hv = 16'h8888; dpv = 4'b0101;
        for (int i = 0; i < 2 * SCAN; i++) begin
            tick();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL dp n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        dpv = 4'h0;
    endtask

    task automatic test_reset_midshow();
        int guard;
        hv = 16'h1234;
        guard = 0;
        do begin tick(); guard++; end while (mpos() != 2 * SLOT + 1 && guard < 2 * SCAN);
        total++;
        if (an_n !== 4'hB) begin
            bad++; $display("FAIL rstmid_pre got=%h exp=b", an_n);
        end
        rst = 1'b1;
        tick();
        total++;
        if (got !== OFF) begin
            bad++; $display("FAIL rstmid_blank got=%h exp=%h", got, OFF);
        end
        rst = 1'b0;
        for (int i = 0; i < SCAN; i++) begin
            tick();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL rstmid n=%0d got=%h exp=%h", n, got, exp);
            end
            if (n == BC) begin
                total++;
                if (an_n !== 4'hE || seg_n !== 7'h19) begin
                    bad++; $display("FAIL rstmid_restart got=%h/%h exp=e/19", an_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                hv  = 16'($urandom);
                dpv = 4'($urandom);
`ifdef HEX_DIGITS_LZ_BLANK_EN
                if ($urandom_range(0, 1) == 1) hv = hv >> (4 * $urandom_range(1, 4));
`endif
            end
            rst = ($urandom_range(0, 149) == 0);
            tick();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL random n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_lz();
        rst = 1'b1; tick(); rst = 1'b0;
        hv = 16'h00A5; dpv = 4'hF;
        for (int i = 0; i < SCAN + BC; i++) begin
            tick();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL lz_00a5 n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        hv = 16'h0000;
        for (int i = 0; i < 2 * SCAN; i++) begin
            tick();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL lz_0000 n=%0d got=%h exp=%h", n, got, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; hv = '0; dpv = '0;
        test_reset();
        test_scan_1234();
        test_decode();
        test_midscan_change();
        test_dp();
        test_reset_midshow();
        test_random();
        test_lz();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
